// File: rtl/mccoy_pkg.sv
// McCoy 8-bit CPU shared definitions: opcodes, sequencer states and field widths.
package mccoy_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_LDR = 3'b010;
    localparam logic [2:0] OP_STR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_LOG = 3'b110;
    localparam logic [2:0] OP_SHF = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_IMM   = 2'd1,
        S_EXEC  = 2'd2,
        S_SHIFT = 2'd3
    } state_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for the McCoy exec unit: ADD, AND/XOR and, when the
// EXEC_SUB_EN macro is defined, SUB. Without EXEC_SUB_EN no subtractor exists.
module exec_alu
    import mccoy_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    input  logic [1:0]        m,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic unused_m;
    assign unused_m = m[0];

    // Select the operation; the 9-bit forms put carry or borrow into bit 8
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
`ifdef EXEC_SUB_EN
            OP_SUB: {carry, result} = {1'b0, a} - {1'b0, b};
`endif
            OP_LOG: result = m[1] ? (a ^ b) : (a & b);
            default: ;
        endcase
    end

endmodule

// File: rtl/exec_unit.sv
// McCoy instruction sequencer and x8 accumulator. Accepts instruction bytes
// over valid/ready, drives the x0-x7 register file and runs iterative shifts.
// Optional macro EXEC_SUB_EN enables opcode 100 as SUB; otherwise it is a NOP.
module exec_unit
    import mccoy_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [DATA_W-1:0] reg_data,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] x8,
    output logic              write_reg,
    output logic              busy,
    output logic              flag_z,
    output logic              flag_c
);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] instr_q;
    logic [2:0]        count;
    logic [2:0]        op_q;
    logic              accept;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_wr;
    logic [DATA_W-1:0] shift_val;
    logic              shift_out;
    logic              unused_instr;

    assign op_q         = instr_q[7:5];
    assign reg_addr     = instr_q[4:2];
    assign unused_instr = instr_q[0];
    assign accept       = instr_valid && instr_ready;
    assign busy         = (state != S_IDLE);
    assign write_reg    = (state == S_EXEC) && (op_q == OP_STR);
    assign shift_val    = instr_q[1] ? (x8 >> 1) : (x8 << 1);
    assign shift_out    = instr_q[1] ? x8[0] : x8[DATA_W-1];

    exec_alu u_alu (
        .a      (x8),
        .b      (reg_data),
        .op     (op_q),
        .m      (instr_q[1:0]),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // Decide which captured opcodes write the ALU result back into x8
    always_comb begin
        alu_wr = (op_q == OP_ADD) || (op_q == OP_LOG);
`ifdef EXEC_SUB_EN
        if (op_q == OP_SUB) alu_wr = 1'b1;
`endif
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state decode and handshake readiness
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_next = (instr[7:5] == OP_LDI) ? S_IMM : S_EXEC;
            end
            S_IMM: begin
                instr_ready = 1'b1;
                if (instr_valid) state_next = S_IDLE;
            end
            S_EXEC: begin
                if ((op_q == OP_SHF) && (reg_data[2:0] != 3'd0)) state_next = S_SHIFT;
                else                                              state_next = S_IDLE;
            end
            S_SHIFT: begin
                if (count == 3'd1) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: instruction capture, accumulator, flags and shift counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x8      <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            instr_q <= '0;
            count   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) instr_q <= instr;
                end
                S_IMM: begin
                    if (accept) begin
                        x8     <= instr;
                        flag_z <= (instr == '0);
                    end
                end
                S_EXEC: begin
                    if (op_q == OP_LDR) begin
                        x8     <= reg_data;
                        flag_z <= (reg_data == '0);
                    end else if (alu_wr) begin
                        x8     <= alu_result;
                        flag_z <= (alu_result == '0);
                        if (op_q != OP_LOG) flag_c <= alu_carry;
                    end else if (op_q == OP_SHF) begin
                        if (reg_data[2:0] == 3'd0) flag_z <= (x8 == '0);
                        else                       count  <= reg_data[2:0];
                    end
                end
                S_SHIFT: begin
                    x8     <= shift_val;
                    flag_c <= shift_out;
                    count  <= count - 3'd1;
                    if (count == 3'd1) flag_z <= (shift_val == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
Instruction sequencer and accumulator (x8) for the McCoy 8-bit CPU, sitting directly upstream of the x0–x7 register file. It accepts instruction bytes over a valid/ready handshake and decodes them. It drives the register file's address and write-enable, and consumes its combinational read data. ALU ops are single-cycle; shifts are iterative, one bit per cycle.

Parameters:
None. Widths are fixed: data 8, register address 3.

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
instr  input  8  instruction byte, or immediate byte while in IMM
instr_valid  input  1  instr holds a valid byte
instr_ready  output  1  block can accept a byte this cycle
reg_data  input  8  read data from register file at reg_addr
reg_addr  output  3  register file address
x8  output  8  accumulator; register file write data
write_reg  output  1  register file write enable (file samples on negedge)
busy  output  1  instruction in progress
flag_z  output  1  zero flag
flag_c  output  1  carry/borrow/shift-out flag

Behaviour:
- Reset (async, immediate): state=IDLE, x8=0, flag_z=0, flag_c=0, captured instr=0, shift count=0. Resulting outputs: reg_addr=0, write_reg=0, busy=0, instr_ready=1.
- Instruction format: op=instr[7:5], r=instr[4:2], m=instr[1:0].
- Opcodes:
  - 000 NOP: no effect.
  - 001 LDI: the next accepted byte is loaded into x8.
  - 010 LDR: x8<=reg_data.
  - 011 STR: reg[r]<=x8.
  - 100 SUB: x8<=x8-reg_data (optional, see below).
  - 101 ADD: x8<=x8+reg_data.
  - 110 LOG: m[1]=0 gives AND, m[1]=1 gives XOR.
  - 111 SHF: shift x8 by reg_data[2:0] positions; m[1]=0 left, 1 right (logical).
- States:
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, capture the byte. LDI goes to IMM; all others go to EXEC.
  - IMM: instr_ready=1. On handshake, x8<=instr and return to IDLE. Waits indefinitely otherwise.
  - EXEC: instr_ready=0, one cycle. Performs the op. SHF with nonzero amount loads count=reg_data[2:0] and goes to SHIFT; every other op returns to IDLE.
  - SHIFT: shift x8 one bit per cycle and decrement count. Return to IDLE when count reaches 1 (after its last shift).
- reg_addr = captured r, driven from the captured-instruction register in all states. It is stable through EXEC.
- write_reg = (state==EXEC && op==STR). It is decoded from flops only and is high for exactly one cycle.
- busy = (state != IDLE).
- Latency, accept edge to x8 update:
  - LDR/ADD/SUB/LOG: 1 cycle. Throughput is one instruction per 2 cycles.
  - SHF: 1+n cycles.
  - LDI: until the immediate byte handshakes.
- Width rules: all arithmetic is mod 256.
  - ADD: flag_c = carry-out.
  - SUB: flag_c = borrow (x8 < reg_data).
  - SHF: flag_c = last bit shifted out.
  - LOG, LDR, LDI: flag_c unchanged.
- flag_z: updated to (new x8==0) on every op that writes x8. SHF updates it on the final shift, or in EXEC when n=0.
- Boundaries:
  - SHF with amount 0: x8 and flag_c unchanged, flag_z recomputed, back to IDLE after EXEC.
  - STR to x0: write_reg is still asserted; the register file discards the write.
  - LDR of x0 yields 0.
  - instr_valid while busy (outside IMM) is ignored, not queued.
  - Reset mid-SHIFT or mid-IMM aborts the instruction. No write_reg pulse occurs after reset.

Optional Feature:
- Macro EXEC_SUB_EN.
- Defined: opcode 100 performs SUB as specified.
- Undefined: opcode 100 decodes as NOP (EXEC one cycle, no x8/flag change), and the subtractor is not synthesised.

Decomposition:
- Package mccoy_pkg:
  - opcode constants OP_NOP … OP_SHF;
  - state encoding constants S_IDLE, S_IMM, S_EXEC, S_SHIFT;
  - field widths DATA_W=8, ADDR_W=3.
- One combinational sub-module exec_alu, covering ADD/SUB/AND/XOR:
  - inputs a, b, op, m;
  - outputs result[7:0], carry.
- exec_unit keeps the FSM, shift logic and flags.

Test Plan:
- Reset then LDI 0x2A (bytes 0x20, 0x2A) -> IMM entered, x8=0x2A, flag_z=0, busy low after the immediate handshake.
- x8=0x2A, STR r=3 (0x6C) -> reg_addr=3, write_reg high exactly one cycle in EXEC; then LDR r=3 (0x4C) reads back x8=0x2A.
- reg[3]=0xF0, x8=0x20, ADD r=3 (0xAC) -> x8=0x10, flag_c=1, flag_z=0, one cycle after accept.
- reg[2]=0x03, x8=0x81, SHF left r=2 (0xE8) -> busy for 4 cycles, x8=0x08, flag_c=0. Repeat with reg[2]=0 -> x8 unchanged, busy 1 cycle.
- x8=0x05, reg[1]=0x05, opcode 100 r=1 (0x84) -> with EXEC_SUB_EN: x8=0x00, flag_z=1, flag_c=0; without it: x8 stays 0x05.
- Assert reset during SHIFT with count=5 -> x8=0, state IDLE, instr_ready=1 immediately, no write_reg pulse; instr_valid during busy is dropped.
